// File: rtl/multdiv_stage.sv
// multdiv_stage: iterative signed 32-bit multiply/divide unit sitting beside DX, stalling the pipe via busy.
// Define MULTDIV_BOOTH_EN to build the radix-4 Booth multiplier (16 iterations); divide is identical in both builds.
module multdiv_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [4:0]  tag_in,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic [4:0]  tag_out,
   output logic        busy
);

`ifdef MULTDIV_BOOTH_EN
   localparam int unsigned HW       = 34;
   localparam logic [4:0]  MUL_LAST = 5'd15;
`else
   localparam int unsigned HW       = 33;
   localparam logic [4:0]  MUL_LAST = 5'd31;
`endif
   localparam logic [4:0]  DIV_LAST = 5'd31;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;
   state_t state_q, state_d;

   logic [4:0]    cnt_q;
   logic          fin_q;
   logic [HW-1:0] hi_q, hi_sum, mul_hi;
   logic [31:0]   lo_q, mul_lo, div_lo;
   logic [31:0]   a_q, b_q, a_abs, b_abs;
   logic          neg_q, ovf_q;
   logic [63:0]   prod;
   logic          mul_ovf, div_zero;
   logic [32:0]   rem_sh, rem_sum;
`ifdef MULTDIV_BOOTH_EN
   logic          bx_q, mul_bx;
   logic [HW-1:0] addend;
`endif

   always_comb begin
      a_abs = data_operandA[31] ? -data_operandA : data_operandA;
      b_abs = data_operandB[31] ? -data_operandB : data_operandB;
   end

`ifdef MULTDIV_BOOTH_EN
   always_comb begin
      case ({lo_q[1:0], bx_q})
         3'b001, 3'b010: addend = {{2{a_q[31]}}, a_q};
         3'b011:         addend = {a_q[31], a_q, 1'b0};
         3'b100:         addend = -{a_q[31], a_q, 1'b0};
         3'b101, 3'b110: addend = -{{2{a_q[31]}}, a_q};
         default:        addend = '0;
      endcase
      hi_sum = hi_q + addend;
      mul_hi = {{2{hi_sum[33]}}, hi_sum[33:2]};
      mul_lo = {hi_sum[1:0], lo_q[31:2]};
      mul_bx = lo_q[1];
   end
`else
   // Multiplier bit 31 carries weight -2^31, so the last partial product is subtracted.
   always_comb begin
      hi_sum = hi_q;
      if (lo_q[0]) begin
         if (cnt_q == MUL_LAST) hi_sum = hi_q - {a_q[31], a_q};
         else                   hi_sum = hi_q + {a_q[31], a_q};
      end
      mul_hi = {hi_sum[32], hi_sum[32:1]};
      mul_lo = {hi_sum[0], lo_q[31:1]};
   end
`endif

   always_comb begin
      prod     = {hi_q[31:0], lo_q};
      mul_ovf  = ~((&prod[63:31]) | ~(|prod[63:31]));
      div_zero = (b_q == '0);
      // Non-restoring step: sign of the partial remainder picks add or subtract.
      rem_sh   = {hi_q[31:0], lo_q[31]};
      rem_sum  = hi_q[32] ? rem_sh + {1'b0, b_q} : rem_sh - {1'b0, b_q};
      div_lo   = {lo_q[30:0], ~rem_sum[32]};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (ctrl_MULT) state_d = S_MULT;
                 else if (ctrl_DIV) state_d = S_DIV;
         S_MULT: if (fin_q) state_d = S_DONE;
         S_DIV:  if (fin_q || div_zero) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      data_resultRDY = (state_q == S_DONE);
      busy           = (state_q != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0; fin_q <= 1'b0; hi_q <= '0; lo_q <= '0;
         a_q <= '0; b_q <= '0; neg_q <= 1'b0; ovf_q <= 1'b0;
         data_result <= '0; data_exception <= 1'b0; tag_out <= '0;
`ifdef MULTDIV_BOOTH_EN
         bx_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (ctrl_MULT || ctrl_DIV) begin
               tag_out <= tag_in;
               cnt_q   <= '0;
               fin_q   <= 1'b0;
               hi_q    <= '0;
`ifdef MULTDIV_BOOTH_EN
               bx_q    <= 1'b0;
`endif
               if (ctrl_MULT) begin
                  a_q  <= data_operandA;
                  lo_q <= data_operandB;
               end else begin
                  lo_q  <= a_abs;
                  b_q   <= b_abs;
                  neg_q <= data_operandA[31] ^ data_operandB[31];
                  ovf_q <= (data_operandA == 32'h8000_0000) && (data_operandB == '1);
               end
            end
            S_MULT: if (!fin_q) begin
               hi_q  <= mul_hi;
               lo_q  <= mul_lo;
`ifdef MULTDIV_BOOTH_EN
               bx_q  <= mul_bx;
`endif
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == MUL_LAST) fin_q <= 1'b1;
            end else begin
               data_result    <= prod[31:0];
               data_exception <= mul_ovf;
            end
            S_DIV: if (div_zero) begin
               data_result    <= '0;
               data_exception <= 1'b1;
            end else if (!fin_q) begin
               hi_q  <= HW'($signed(rem_sum));
               lo_q  <= div_lo;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == DIV_LAST) fin_q <= 1'b1;
            end else begin
               data_result    <= neg_q ? -lo_q : lo_q;
               data_exception <= ovf_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_stage.sv
// Directed-vector bench for multdiv_stage: results, exceptions, latency, strobe blocking and async reset abort.
module tb_multdiv_stage;

`ifdef MULTDIV_BOOTH_EN
   localparam int MUL_LAT = 17;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clock, reset;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [4:0]  tag_in;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;
   logic [4:0]  tag_out;
   logic        busy;

   int checks = 0;
   int errors = 0;

   multdiv_stage dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .tag_in         (tag_in),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .tag_out        (tag_out),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_rdy(input int start_n, output int n);
      bit seen;
      n = start_n;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge clock); #1;
         n++;
         seen = data_resultRDY;
      end
   endtask

   task automatic finish_op(input string name, input int n, input int exp_lat,
                            input logic [31:0] exp_r, input logic exp_e, input logic [4:0] exp_tag);
      check({name, " latency"}, n, exp_lat);
      check({name, " result"}, data_result, exp_r);
      check({name, " exc"}, {31'b0, data_exception}, {31'b0, exp_e});
      check({name, " tag"}, {27'b0, tag_out}, {27'b0, exp_tag});
      @(posedge clock); #1;
      check({name, " rdy pulse width"}, {31'b0, data_resultRDY}, 32'd0);
      check({name, " idle busy"}, {31'b0, busy}, 32'd0);
      check({name, " result held"}, data_result, exp_r);
   endtask

   task automatic run_op(input string name, input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_r, input logic exp_e, input int exp_lat);
      int n;
      @(negedge clock);
      ctrl_MULT = is_mult; ctrl_DIV = !is_mult;
      data_operandA = a; data_operandB = b; tag_in = tag;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h0BAD_F00D; tag_in = 5'd31;
      check({name, " busy"}, {31'b0, busy}, 32'd1);
      wait_rdy(0, n);
      finish_op(name, n, exp_lat, exp_r, exp_e, tag);
   endtask

   initial begin
      int n;
      reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = '0; data_operandB = '0; tag_in = '0;
      #3 reset = 1'b0;
      #1;
      check("rst result", data_result, 32'd0);
      check("rst rdy", {31'b0, data_resultRDY}, 32'd0);
      check("rst busy", {31'b0, busy}, 32'd0);
      check("rst tag", {27'b0, tag_out}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      run_op("mul 7x-3",      1'b1, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0, MUL_LAT);
      run_op("mul 2^16x2^16", 1'b1, 32'h0001_0000,  32'h0001_0000, 5'd2,  32'h0000_0000, 1'b1, MUL_LAT);
      run_op("mul max x1",    1'b1, 32'h7FFF_FFFF,  32'd1,         5'd4,  32'h7FFF_FFFF, 1'b0, MUL_LAT);
      run_op("mul min x-1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  32'h8000_0000, 1'b1, MUL_LAT);
      run_op("mul -5x-6",     1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 5'd7,  32'h0000_001E, 1'b0, MUL_LAT);
      run_op("mul min x min", 1'b1, 32'h8000_0000,  32'h8000_0000, 5'd8,  32'h0000_0000, 1'b1, MUL_LAT);
      run_op("div -7/2",      1'b0, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
      run_op("div 100/7",     1'b0, 32'd100,        32'd7,         5'd11, 32'd14,        1'b0, DIV_LAT);
      run_op("div 5/0",       1'b0, 32'd5,          32'd0,         5'd13, 32'd0,         1'b1, 1);
      run_op("div min/-1",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b1, DIV_LAT);
      run_op("div 7/-2",      1'b0, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 1'b0, DIV_LAT);

      // DIV strobe at E5 of a multiply must be ignored.
      @(negedge clock);
      ctrl_MULT = 1'b1; data_operandA = 32'h0001_2345; data_operandB = 32'h10; tag_in = 5'd3;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7; tag_in = 5'd9;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      wait_rdy(5, n);
      finish_op("blocked strobe", n, MUL_LAT, 32'h0012_3450, 1'b0, 5'd3);

      // Reset asserted just after E10 of a divide.
      @(negedge clock);
      ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7; tag_in = 5'd12;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      repeat (10) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("abort result", data_result, 32'd0);
      check("abort exc", {31'b0, data_exception}, 32'd0);
      check("abort rdy", {31'b0, data_resultRDY}, 32'd0);
      check("abort tag", {27'b0, tag_out}, 32'd0);
      check("abort busy", {31'b0, busy}, 32'd0);
      ctrl_MULT = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("strobe in reset busy", {31'b0, busy}, 32'd0);
      check("strobe in reset rdy", {31'b0, data_resultRDY}, 32'd0);
      ctrl_MULT = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      run_op("mul after reset", 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, MUL_LAT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
